// File: rtl/dmem_arbiter_if.sv
// Bundles the two requester ports and the data-memory bus of dmem_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int A_WIDTH = 28
) ();
    logic               req0_valid, req0_ready, req0_we, req0_uns, req0_done;
    logic [1:0]         req0_size;
    logic [A_WIDTH-1:0] req0_addr;
    logic [31:0]        req0_wdata, req0_rdata;

    logic               req1_valid, req1_ready, req1_we, req1_uns, req1_done;
    logic [1:0]         req1_size;
    logic [A_WIDTH-1:0] req1_addr;
    logic [31:0]        req1_wdata, req1_rdata;

    logic [A_WIDTH-1:0] mem_A;
    logic [31:0]        mem_WD;
    logic               mem_WE;
    logic [31:0]        mem_RD;

    modport master (
        input  req0_valid, req0_we, req0_size, req0_uns, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_size, req1_uns, req1_addr, req1_wdata,
        output req0_ready, req0_rdata, req0_done,
        output req1_ready, req1_rdata, req1_done,
        output mem_A, mem_WD, mem_WE,
        input  mem_RD
    );

    modport slave (
        output req0_valid, req0_we, req0_size, req0_uns, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_size, req1_uns, req1_addr, req1_wdata,
        input  req0_ready, req0_rdata, req0_done,
        input  req1_ready, req1_rdata, req1_done,
        input  mem_A, mem_WD, mem_WE,
        output mem_RD
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (core/DMA) arbiter onto a single big-endian data memory with RMW sub-word stores.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int A_WIDTH = 28,
    parameter int W_WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RST,
    dmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t               state_q, state_d;
    logic                 port_q, port_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    // Word stores take their data at acceptance; only sub-word RMW needs the low half later.
    logic [15:0]          wdata_q, wdata_d;
    logic [A_WIDTH-1:0]   mem_a_q, mem_a_d;
    logic [W_WIDTH-1:0]   mem_wd_q, mem_wd_d;
    logic                 mem_we_q, mem_we_d;
    logic [1:0]           done_q, done_d;
    logic [W_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic                 any_valid, accept, gnt_port;
    logic                 sel_we, sel_uns;
    logic [1:0]           sel_size;
    logic [A_WIDTH-1:0]   sel_addr;
    logic [31:0]          sel_wdata;
    logic [W_WIDTH-1:0]   load_ext;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign accept    = (state_q == IDLE) & any_valid & ~RST;

`ifdef DMEM_ARB_RR_EN
    logic rr_q, rr_d;

    // rr_q = 1 means port 1 is preferred on the next contended grant.
    always_comb begin
        gnt_port = bus.req1_valid & (~bus.req0_valid | rr_q);
        rr_d     = rr_q;
        if (accept) rr_d = ~gnt_port;
    end

    always_ff @(posedge CLK) begin
        if (RST) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`else
    assign gnt_port = ~bus.req0_valid;
`endif

    assign bus.req0_ready = accept & ~gnt_port;
    assign bus.req1_ready = accept &  gnt_port;

    assign sel_we    = gnt_port ? bus.req1_we    : bus.req0_we;
    assign sel_uns   = gnt_port ? bus.req1_uns   : bus.req0_uns;
    assign sel_size  = gnt_port ? bus.req1_size  : bus.req0_size;
    assign sel_addr  = gnt_port ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = gnt_port ? bus.req1_wdata : bus.req0_wdata;

    // Big-endian: the addressed byte sits in the top bits of the read word.
    always_comb begin
        load_ext = bus.mem_RD;
        if (!size_q[1]) begin
            if (size_q[0]) load_ext = {{16{~uns_q & bus.mem_RD[31]}}, bus.mem_RD[31:16]};
            else           load_ext = {{24{~uns_q & bus.mem_RD[31]}}, bus.mem_RD[31:24]};
        end
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        mem_a_d  = '0;
        mem_wd_d = '0;
        mem_we_d = 1'b0;
        done_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d  = gnt_port;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    uns_d   = sel_uns;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata[15:0];
                    mem_a_d = sel_addr;
                    if (sel_we && sel_size[1]) begin
                        state_d  = WR;
                        mem_we_d = 1'b1;
                        mem_wd_d = sel_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d  = WR;
                    mem_we_d = 1'b1;
                    mem_a_d  = addr_q;
                    mem_wd_d = size_q[0] ? {wdata_q[15:0], bus.mem_RD[15:0]}
                                         : {wdata_q[7:0],  bus.mem_RD[23:0]};
                end else begin
                    state_d        = IDLE;
                    done_d[port_q] = 1'b1;
                    if (port_q) rdata1_d = load_ext;
                    else        rdata0_d = load_ext;
                end
            end
            WR: begin
                state_d        = IDLE;
                done_d[port_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            mem_we_q <= 1'b0;
            done_q   <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            mem_we_q <= mem_we_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.mem_A      = mem_a_q;
    assign bus.mem_WD     = mem_wd_q;
    assign bus.mem_WE     = mem_we_q;
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stores, loads, RMW, contention and reset mid-operation.
// Expected grant order follows DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   gnts[$];

    dmem_arbiter_if #(.A_WIDTH(28)) bus ();

    dmem_arbiter #(.A_WIDTH(28), .W_WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Byte-addressed memory, big-endian word view at mem_A
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = bus.mem_A[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign bus.mem_RD = {mem[a0], mem[a1], mem[a2], mem[a3]};

    always @(posedge CLK) begin
        if (bus.mem_WE) begin
            mem[a0] <= bus.mem_WD[31:24];
            mem[a1] <= bus.mem_WD[23:16];
            mem[a2] <= bus.mem_WD[15:8];
            mem[a3] <= bus.mem_WD[7:0];
        end
    end

    function automatic logic [31:0] memw(input logic [7:0] ad);
        logic [7:0] b1, b2, b3;
        b1 = ad + 8'd1;
        b2 = ad + 8'd2;
        b3 = ad + 8'd3;
        return {mem[ad], mem[b1], mem[b2], mem[b3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge with valid dropped.
    task automatic issue(input logic p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [27:0] ad, input logic [31:0] wd, input string tag);
        if (p) begin
            bus.req1_we = we; bus.req1_size = sz; bus.req1_uns = uns;
            bus.req1_addr = ad; bus.req1_wdata = wd; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_we = we; bus.req0_size = sz; bus.req0_uns = uns;
            bus.req0_addr = ad; bus.req0_wdata = wd; bus.req0_valid = 1'b1;
        end
        #1;
        chk({tag, "_ready0"}, {31'd0, bus.req0_ready}, {31'd0, ~p});
        chk({tag, "_ready1"}, {31'd0, bus.req1_ready}, {31'd0, p});
        @(posedge CLK);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    int exp_g [4];

    initial begin
`ifdef DMEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_size = 0; bus.req0_uns = 0;
        bus.req0_addr = 0;  bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_size = 0; bus.req1_uns = 0;
        bus.req1_addr = 0;  bus.req1_wdata = 0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk("rst_done",  {30'd0, bus.req1_done, bus.req0_done}, 32'd0);
        chk("rst_rdata0", bus.req0_rdata, 32'd0);
        chk("rst_rdata1", bus.req1_rdata, 32'd0);
        chk("rst_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("rst_a",  {4'd0, bus.mem_A}, 32'd0);
        chk("rst_wd", bus.mem_WD, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Word store, port 0
        issue(1'b0, 1'b1, 2'b10, 1'b0, 28'h10, 32'hDEADBEEF, "wst");
        @(negedge CLK);
        chk("wst_c1_we", {31'd0, bus.mem_WE}, 32'd1);
        chk("wst_c1_a",  {4'd0, bus.mem_A}, 32'h10);
        chk("wst_c1_wd", bus.mem_WD, 32'hDEADBEEF);
        chk("wst_c1_done", {31'd0, bus.req0_done}, 32'd0);
        @(negedge CLK);
        chk("wst_c2_done", {31'd0, bus.req0_done}, 32'd1);
        chk("wst_c2_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("wst_c2_a",  {4'd0, bus.mem_A}, 32'd0);
        chk("wst_mem", memw(8'h10), 32'hDEADBEEF);
        @(negedge CLK);
        chk("wst_c3_done", {31'd0, bus.req0_done}, 32'd0);

        // Preload 0x80 at 0x10, then signed and unsigned byte loads on port 1
        issue(1'b0, 1'b1, 2'b11, 1'b0, 28'h10, 32'h80000000, "pre80");
        repeat (2) @(negedge CLK);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 28'h10, 32'h0, "lbs");
        @(negedge CLK);
        chk("lbs_c1_a",  {4'd0, bus.mem_A}, 32'h10);
        chk("lbs_c1_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("lbs_c1_done", {31'd0, bus.req1_done}, 32'd0);
        @(negedge CLK);
        chk("lbs_done1", {31'd0, bus.req1_done}, 32'd1);
        chk("lbs_done0", {31'd0, bus.req0_done}, 32'd0);
        chk("lbs_rdata1", bus.req1_rdata, 32'hFFFFFF80);
        chk("lbs_rdata0_held", bus.req0_rdata, 32'd0);
        issue(1'b1, 1'b0, 2'b00, 1'b1, 28'h10, 32'h0, "lbu");
        repeat (2) @(negedge CLK);
        chk("lbu_rdata1", bus.req1_rdata, 32'h00000080);

        // Signed half load on port 0; port 1 result must stay put
        issue(1'b0, 1'b0, 2'b01, 1'b0, 28'h10, 32'h0, "lhs");
        repeat (2) @(negedge CLK);
        chk("lhs_rdata0", bus.req0_rdata, 32'hFFFF8000);
        chk("lhs_rdata1_held", bus.req1_rdata, 32'h00000080);

        // Byte store RMW over 11 22 33 44; idle-port noise must not matter
        issue(1'b0, 1'b1, 2'b10, 1'b0, 28'h10, 32'h11223344, "pre1234");
        repeat (2) @(negedge CLK);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 28'h10, 32'h000000AB, "sb");
        bus.req0_wdata = 32'h55555555; bus.req0_addr = 28'h40;
        bus.req1_wdata = 32'h66666666; bus.req1_addr = 28'h44; bus.req1_size = 2'b10;
        @(negedge CLK);
        chk("sb_c1_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("sb_c1_a",  {4'd0, bus.mem_A}, 32'h10);
        @(negedge CLK);
        chk("sb_c2_we", {31'd0, bus.mem_WE}, 32'd1);
        chk("sb_c2_wd", bus.mem_WD, 32'hAB223344);
        chk("sb_c2_done", {31'd0, bus.req0_done}, 32'd0);
        @(negedge CLK);
        chk("sb_c3_done", {31'd0, bus.req0_done}, 32'd1);
        chk("sb_mem", memw(8'h10), 32'hAB223344);

        // Half store RMW
        issue(1'b0, 1'b1, 2'b01, 1'b0, 28'h10, 32'h0000CAFE, "sh");
        repeat (2) @(negedge CLK);
        chk("sh_wd", bus.mem_WD, 32'hCAFE3344);
        @(negedge CLK);
        chk("sh_done", {31'd0, bus.req0_done}, 32'd1);
        chk("sh_mem", memw(8'h10), 32'hCAFE3344);

        // Contention from a fresh reset so the pointer prefers port 0
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        bus.req0_we = 0; bus.req0_size = 2'b10; bus.req0_addr = 28'h10; bus.req0_valid = 1;
        bus.req1_we = 0; bus.req1_size = 2'b10; bus.req1_addr = 28'h10; bus.req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) chk("both_ready", 32'd1, 32'd0);
            if (bus.req0_ready) gnts.push_back(0);
            else if (bus.req1_ready) gnts.push_back(1);
            @(negedge CLK);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("cont_ngrants", gnts.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cont_g%0d", i), (i < gnts.size()) ? gnts[i] : 32'hFFFFFFFF, exp_g[i]);
        repeat (2) @(negedge CLK);

        // Reset during RD of a half store on port 1
        issue(1'b1, 1'b1, 2'b01, 1'b0, 28'h10, 32'h00001234, "rsth");
        @(negedge CLK);
        chk("rsth_c1_we", {31'd0, bus.mem_WE}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rsth_c2_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("rsth_c2_done", {30'd0, bus.req1_done, bus.req0_done}, 32'd0);
        chk("rsth_c2_a", {4'd0, bus.mem_A}, 32'd0);
        @(negedge CLK);
        chk("rsth_c3_we", {31'd0, bus.mem_WE}, 32'd0);
        chk("rsth_c3_done", {30'd0, bus.req1_done, bus.req0_done}, 32'd0);
        chk("rsth_mem", memw(8'h10), 32'hCAFE3344);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 28'h10, 32'h0, "post");
        repeat (2) @(negedge CLK);
        chk("post_done", {31'd0, bus.req0_done}, 32'd1);
        chk("post_rdata0", bus.req0_rdata, 32'hCAFE3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
